sync_fifo_param: RTL

Parametrised synchronous FIFO: the next-generation replacement for the team's fixed 8-bit / 16-entry FIFO. Adds configurable data width and depth, an occupancy count, programmable almost-full/almost-empty flags, defined simultaneous read/write behaviour at full and empty, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain and is the standard buffer for new datapath blocks.

---
 rtl/sync_fifo_param.sv | 61 ++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised first-word-fall-through synchronous FIFO with level flags and sticky errors
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  if (ADDR_WIDTH < 1 || AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_params
    $error("sync_fifo_param: illegal ADDR_WIDTH/AF_LEVEL/AE_LEVEL");
  end
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_ovf, r_udf;
  logic                  w_rd_acc, w_wr_acc;
  // A write while full is only accepted when a read frees the head slot in the same cycle.
  assign w_rd_acc     = rd & ~empty;
  assign w_wr_acc     = wr & (~full | rd);
  assign r_data       = r_mem[r_rptr];
  assign count        = r_count;
  assign empty        = r_count == '0;
  assign full         = r_count == (ADDR_WIDTH+1)'(DEPTH);
  assign almost_empty = r_count <= (ADDR_WIDTH+1)'(AE_LEVEL);
  assign almost_full  = r_count >= (ADDR_WIDTH+1)'(AF_LEVEL);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= w_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_wptr  <= r_wptr + ADDR_WIDTH'(w_wr_acc);
      r_rptr  <= r_rptr + ADDR_WIDTH'(w_rd_acc);
      r_count <= r_count + (ADDR_WIDTH+1)'(w_wr_acc) - (ADDR_WIDTH+1)'(w_rd_acc);
      r_ovf   <= (wr & ~w_wr_acc) | (r_ovf & ~err_clr);
      r_udf   <= (rd & empty) | (r_udf & ~err_clr);
    end
  end
endmodule
